// File: rtl/dmem_pkg.sv
// +--------------------------------------------------------------------------+
// | dmem_pkg: shared FSM state, access-size encodings and lane helpers for    |
// | the dmem_responder data-memory slave.                                     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Misaligned offsets fall onto the naturally aligned lanes of the same word.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] m;
    case (size)
      SZ_B:    m = 4'b0001 << lo;
      SZ_H:    m = lo[1] ? 4'b1100 : 4'b0011;
      SZ_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] wdata_lanes(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] r;
    case (size)
      SZ_B:    r = {4{wd[7:0]}};
      SZ_H:    r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extend(input logic [1:0] size, input logic [1:0] lo,
                                              input logic uns, input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    r = {{24{b[7] & ~uns}}, b};
      SZ_H:    r = {{16{h[15] & ~uns}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// +--------------------------------------------------------------------------+
// | dmem_array: single-port synchronous RAM with per-byte write enables.      |
// | Read data is registered and holds until the next read access.            |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module dmem_array #(
  parameter int WIDTH       = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 8
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [WIDTH/8-1:0]   be,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < WIDTH/8; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// +--------------------------------------------------------------------------+
// | dmem_responder: valid/ready load/store slave with fixed wait states in   |
// | front of a byte-lane RAM. Define DMEM_MISALIGN_TRAP_EN to fault           |
// | misaligned half/word accesses instead of aligning them down.              |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module dmem_responder
  import dmem_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err
);

  localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t             state;
  logic [3:0]         cnt;
  logic               write_q, uns_q, load_ok;
  logic [WIDTH-1:0]   addr_q, wdata_q;
  logic [1:0]         size_q;

  logic               cur_write;
  logic [WIDTH-1:0]   cur_addr, cur_wdata;
  logic [1:0]         cur_size;
  logic               out_of_range, misalign, fault, access;
  logic [WIDTH-1:0]   ram_rdata;

  // The zero-wait path accesses memory on the accept edge, before the latch.
  assign cur_write = (state == ST_IDLE) ? req_write : write_q;
  assign cur_addr  = (state == ST_IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state == ST_IDLE) ? req_wdata : wdata_q;
  assign cur_size  = (state == ST_IDLE) ? req_size  : size_q;

  assign out_of_range = {2'b00, cur_addr[WIDTH-1:2]} >= WIDTH'(DEPTH_WORDS);
`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = ((cur_size == SZ_H) && cur_addr[0]) ||
                    ((cur_size == SZ_W) && (cur_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif
  assign fault  = (cur_size == 2'b11) || out_of_range || misalign;
  assign access = !rst && (((state == ST_IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                           ((state == ST_WAIT) && (cnt == 4'd0)));

  dmem_array #(
    .WIDTH       (WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (AW)
  ) u_array (
    .clk   (clk),
    .en    (access && !fault),
    .we    (cur_write),
    .be    (lane_mask(cur_size, cur_addr[1:0])),
    .addr  (cur_addr[AW+1:2]),
    .wdata (wdata_lanes(cur_size, cur_wdata)),
    .rdata (ram_rdata)
  );

  assign rsp_rdata = load_ok ? load_extend(size_q, addr_q[1:0], uns_q, ram_rdata) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      load_ok   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            write_q   <= req_write;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            size_q    <= req_size;
            uns_q     <= req_unsigned;
            req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= fault;
              load_ok   <= !cur_write && !fault;
            end else begin
              state <= ST_WAIT;
              cnt   <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= fault;
            load_ok   <= !cur_write && !fault;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            load_ok   <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
